pkt_proc_deq_ctrl: RTL and testbench

- Downstream consumer of the packet processor: issues deq_req, captures returned out_sop/rd_data_o/out_eop words and re-frames them onto a valid/ready egress stream.
- Credit-based issue plus a small skid FIFO guarantees no returned word is ever lost under egress backpressure.
- Checks SOP/EOP framing, tags the per-packet word length on the EOP beat, and keeps statistics.

---
 rtl/pkt_proc_pkg.sv | 23 ++
 rtl/pkt_proc_deq_skid.sv | 56 +++++
 rtl/pkt_proc_deq_ctrl.sv | 136 +++++++++++++
 tb/tb_pkt_proc_deq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_proc_pkg.sv
// Shared types and constants for the packet-processor dequeue controller.
package pkt_proc_pkg;

  localparam int DEQ_CNT_W  = 16;
  localparam int DEQ_DATA_W = 32;
  localparam int DEQ_LEN_W  = 12;

  typedef enum logic {SEEK_SOP, IN_PKT} deq_state_t;

  typedef struct packed {
    logic [DEQ_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [DEQ_LEN_W-1:0]  len;
  } deq_word_t;

  // Length increment that sticks at the all-ones value.
  function automatic logic [DEQ_LEN_W-1:0] len_inc(input logic [DEQ_LEN_W-1:0] l);
    return (&l) ? l : l + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_proc_deq_skid.sv
// Synchronous skid FIFO of framed egress words with occupancy count.
module pkt_proc_deq_skid
  import pkt_proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   pck_proc_int_mem_fsm_clk,
  input  logic                   pck_proc_int_mem_fsm_sw_rst,
  input  logic                   push,
  input  deq_word_t              push_word,
  input  logic                   pop,
  output deq_word_t              head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_C = (AW+1)'(DEPTH);

  deq_word_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define what is valid.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  a_no_push_on_full : assert property (
    @(posedge pck_proc_int_mem_fsm_clk) disable iff (pck_proc_int_mem_fsm_sw_rst)
      !(push && full && !pop));

endmodule

// File: rtl/pkt_proc_deq_ctrl.sv
// Dequeue controller: credit-based read issue, SOP/EOP re-framing, skid FIFO egress.
// Optional statistics counters are built when PKT_DEQ_STATS_EN is defined.
module pkt_proc_deq_ctrl
  import pkt_proc_pkg::*;
#(
  parameter int DATA_W     = DEQ_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4,
  parameter int LEN_W      = DEQ_LEN_W
) (
  input  logic                 pck_proc_int_mem_fsm_clk,
  input  logic                 pck_proc_int_mem_fsm_sw_rst,
  input  logic                 deq_en,
  input  logic                 pck_proc_empty,
  output logic                 deq_req,
  input  logic                 out_sop,
  input  logic                 out_eop,
  input  logic [DATA_W-1:0]    rd_data_o,
  output logic                 eg_valid,
  input  logic                 eg_ready,
  output logic [DATA_W-1:0]    eg_data,
  output logic                 eg_sop,
  output logic                 eg_eop,
  output logic [LEN_W-1:0]     eg_len,
  output logic                 eg_err,
  output logic                 busy,
  output logic [DEQ_CNT_W-1:0] pkt_cnt,
  output logic [DEQ_CNT_W-1:0] err_cnt
);

  localparam int            CW      = $clog2(SKID_DEPTH) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(SKID_DEPTH);

  logic [RD_LAT-1:0] inflight;
  logic [CW-1:0]     infl_cnt;
  logic [CW-2:0]     fifo_count;
  logic              fifo_empty;
  logic              tap;
  deq_state_t        state, state_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              push;
  logic              err_inc;
  logic              pop;
  deq_word_t         push_word;
  deq_word_t         head;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + CW'(inflight[i]);
  end

  // Credits count both queued and still-returning words, so a push can never overflow.
  assign deq_req = ~pck_proc_int_mem_fsm_sw_rst & deq_en & ~pck_proc_empty &
                   ((CW'(fifo_count) + infl_cnt) < DEPTH_C);
  assign tap     = inflight[RD_LAT-1];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    len_nxt        = len_q;
    push           = 1'b0;
    err_inc        = 1'b0;
    push_word      = '0;
    push_word.data = rd_data_o;
    push_word.eop  = out_eop;
    if (tap) begin
      if (out_sop) begin
        push          = 1'b1;
        push_word.sop = 1'b1;
        push_word.err = (state == IN_PKT);
        push_word.len = out_eop ? LEN_W'(1) : '0;
        err_inc       = (state == IN_PKT);
        len_nxt       = LEN_W'(1);
        state_nxt     = out_eop ? SEEK_SOP : IN_PKT;
      end else if (state == IN_PKT) begin
        push          = 1'b1;
        len_nxt       = len_inc(len_q);
        push_word.len = out_eop ? len_nxt : '0;
        push_word.err = out_eop & (&len_nxt);
        if (out_eop) state_nxt = SEEK_SOP;
      end else begin
        err_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      inflight <= '0;
      state    <= SEEK_SOP;
      len_q    <= '0;
    end else begin
      inflight <= RD_LAT'({inflight, deq_req});
      state    <= state_nxt;
      len_q    <= len_nxt;
    end
  end

  pkt_proc_deq_skid #(.DEPTH(SKID_DEPTH)) u_skid (
    .pck_proc_int_mem_fsm_clk   (pck_proc_int_mem_fsm_clk),
    .pck_proc_int_mem_fsm_sw_rst(pck_proc_int_mem_fsm_sw_rst),
    .push                       (push),
    .push_word                  (push_word),
    .pop                        (pop),
    .head                       (head),
    .empty                      (fifo_empty),
    .count                      (fifo_count)
  );

  assign eg_valid = ~fifo_empty;
  assign pop      = eg_valid & eg_ready;
  assign eg_data  = fifo_empty ? '0 : head.data;
  assign eg_sop   = ~fifo_empty & head.sop;
  assign eg_eop   = ~fifo_empty & head.eop;
  assign eg_err   = ~fifo_empty & head.err;
  assign eg_len   = fifo_empty ? '0 : head.len;
  assign busy     = (|inflight) | ~fifo_empty;

`ifdef PKT_DEQ_STATS_EN
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pop && head.eop) pkt_cnt <= pkt_cnt + 1'b1;
      if (err_inc)         err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = err_inc;
  assign pkt_cnt      = '0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_pkt_proc_deq_ctrl.sv
// Directed bench for pkt_proc_deq_ctrl with a read-latency memory model and egress scoreboard.
module tb_pkt_proc_deq_ctrl;
  import pkt_proc_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int SKID_DEPTH = 4;
`ifdef PKT_DEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } src_t;

  logic        clk;
  logic        rst;
  logic        deq_en;
  logic        pck_proc_empty;
  logic        deq_req;
  logic        out_sop;
  logic        out_eop;
  logic [31:0] rd_data_o;
  logic        eg_valid;
  logic        eg_ready;
  logic [31:0] eg_data;
  logic        eg_sop;
  logic        eg_eop;
  logic [11:0] eg_len;
  logic        eg_err;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  src_t      src_q[$];
  deq_word_t exp_q[$];
  logic      pipe_v [RD_LAT];
  src_t      pipe_w [RD_LAT];
  logic      m_in;
  logic [11:0] m_len;
  int        beats;
  logic [11:0] last_len;

  pkt_proc_deq_ctrl #(.DATA_W(32), .RD_LAT(RD_LAT), .SKID_DEPTH(SKID_DEPTH), .LEN_W(12)) dut (
    .pck_proc_int_mem_fsm_clk   (clk),
    .pck_proc_int_mem_fsm_sw_rst(rst),
    .deq_en                     (deq_en),
    .pck_proc_empty             (pck_proc_empty),
    .deq_req                    (deq_req),
    .out_sop                    (out_sop),
    .out_eop                    (out_eop),
    .rd_data_o                  (rd_data_o),
    .eg_valid                   (eg_valid),
    .eg_ready                   (eg_ready),
    .eg_data                    (eg_data),
    .eg_sop                     (eg_sop),
    .eg_eop                     (eg_eop),
    .eg_len                     (eg_len),
    .eg_err                     (eg_err),
    .busy                       (busy),
    .pkt_cnt                    (pkt_cnt),
    .err_cnt                    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference framing: produces the beat a returned word should become, if any.
  task automatic model_word(input src_t w);
    deq_word_t e;
    e      = '0;
    e.data = w.data;
    e.eop  = w.eop;
    if (w.sop) begin
      e.sop = 1'b1;
      e.err = m_in;
      e.len = w.eop ? 12'd1 : 12'd0;
      exp_q.push_back(e);
      m_len = 12'd1;
      m_in  = !w.eop;
    end else if (m_in) begin
      if (m_len != 12'hFFF) m_len = m_len + 12'd1;
      e.err = w.eop && (m_len == 12'hFFF);
      e.len = w.eop ? m_len : 12'd0;
      exp_q.push_back(e);
      if (w.eop) m_in = 1'b0;
    end
  endtask

  // Egress monitor plus memory model returning words RD_LAT cycles after each request.
  always @(negedge clk) begin
    deq_word_t e;
    deq_word_t got;
    src_t      w;
    if (rst) begin
      exp_q.delete();
      m_in  = 1'b0;
      m_len = '0;
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
    end else if (eg_valid && eg_ready) begin
      check("beat_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        got.data = eg_data;
        got.sop  = eg_sop;
        got.eop  = eg_eop;
        got.err  = eg_err;
        got.len  = eg_len;
        check("beat", 64'(got), 64'(e));
        beats++;
        if (eg_eop) last_len = eg_len;
      end
    end
    if (pipe_v[RD_LAT-1]) begin
      w         = pipe_w[RD_LAT-1];
      out_sop   = w.sop;
      out_eop   = w.eop;
      rd_data_o = w.data;
      if (!rst) model_word(w);
    end else begin
      out_sop   = 1'b1;
      out_eop   = 1'($urandom_range(0, 1));
      rd_data_o = $urandom;
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_w[i] = pipe_w[i-1];
    end
    pipe_v[0] = deq_req && (src_q.size() > 0);
    if (pipe_v[0]) pipe_w[0] = src_q.pop_front();
  end

  always @(posedge clk) begin
    #2;
    pck_proc_empty = (src_q.size() == 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic sop, input logic eop, input logic [31:0] data);
    src_t s;
    s.sop  = sop;
    s.eop  = eop;
    s.data = data;
    src_q.push_back(s);
  endtask

  task automatic add_pkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) add(i == 0, i == n - 1, base + 32'(i));
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && !eg_valid && !busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < bound), 64'd1);
    step();
  endtask

  initial begin
    int n;
    int b0;
    logic [31:0] held;
    rst            = 1'b1;
    deq_en         = 1'b0;
    pck_proc_empty = 1'b1;
    eg_ready       = 1'b1;
    out_sop        = 1'b0;
    out_eop        = 1'b0;
    rd_data_o      = '0;
    m_in           = 1'b0;
    m_len          = '0;
    beats          = 0;
    last_len       = '0;
    repeat (2) step();
    @(negedge clk);
    check("rst_eg_valid", 64'(eg_valid), 64'd0);
    check("rst_deq_req",  64'(deq_req),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_eg_beat",  64'({eg_data, eg_sop, eg_eop, eg_len, eg_err}), 64'd0);
    check("rst_counters", 64'({pkt_cnt, err_cnt}), 64'd0);
    step();
    rst    = 1'b0;
    deq_en = 1'b1;
    step();

    // Three-word packet: latency and back-to-back throughput.
    add(1'b1, 1'b0, 32'hA0);
    add(1'b0, 1'b0, 32'hA1);
    add(1'b0, 1'b1, 32'hA2);
    n = 0;
    do begin @(negedge clk); n++; end while (!deq_req && n < 10);
    check("first_req_seen", 64'(deq_req), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!eg_valid && n < 10);
    check("first_word_latency", 64'(n), 64'(RD_LAT + 1));
    @(negedge clk);
    check("b2b_beat2", 64'(eg_valid), 64'd1);
    @(negedge clk);
    check("b2b_beat3", 64'({eg_valid, eg_eop, eg_len}), 64'({1'b1, 1'b1, 12'd3}));
    drain("drain_pkt_a", 100);
    check("pkt_cnt_a", 64'(pkt_cnt), STATS ? 64'd1 : 64'd0);

    // Egress stalled for 20 cycles: credits cap issue at the FIFO depth.
    eg_ready = 1'b0;
    add_pkt(6, 32'hB0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (deq_req) n++;
      if (i == 5) held = eg_data;
    end
    check("stall_req_count", 64'(n), 64'(SKID_DEPTH));
    check("stall_hold_data", 64'({eg_valid, eg_data}), 64'({1'b1, held}));
    check("stall_busy", 64'(busy), 64'd1);
    step();
    eg_ready = 1'b1;
    drain("drain_pkt_b", 100);
    check("pkt_cnt_b", 64'(pkt_cnt), STATS ? 64'd2 : 64'd0);

    // Word without sop while seeking: dropped and counted.
    b0 = beats;
    add(1'b0, 1'b1, 32'hC0);
    drain("drain_no_sop", 100);
    check("no_sop_beats", 64'(beats - b0), 64'd0);
    check("no_sop_err_cnt", 64'(err_cnt), STATS ? 64'd1 : 64'd0);

    // Aborted packet: sop, d, sop, d, eop.
    add(1'b1, 1'b0, 32'hD0);
    add(1'b0, 1'b0, 32'hD1);
    add(1'b1, 1'b0, 32'hD2);
    add(1'b0, 1'b0, 32'hD3);
    add(1'b0, 1'b1, 32'hD4);
    drain("drain_abort", 100);
    check("abort_eop_len", 64'(last_len), 64'd3);
    check("abort_err_cnt", 64'(err_cnt), STATS ? 64'd2 : 64'd0);
    check("abort_pkt_cnt", 64'(pkt_cnt), STATS ? 64'd3 : 64'd0);

    // Reset with one word queued and one read still in flight.
    eg_ready = 1'b0;
    add_pkt(4, 32'hE0);
    step();
    step();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    src_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(eg_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_counters", 64'({pkt_cnt, err_cnt}), 64'd0);
    repeat (3) @(negedge clk);
    check("post_rst_discard", 64'({eg_valid, busy}), 64'd0);
    step();
    eg_ready = 1'b1;

    // Single-word packet.
    b0 = beats;
    add(1'b1, 1'b1, 32'hF0);
    drain("drain_single", 100);
    check("single_beats", 64'(beats - b0), 64'd1);
    check("single_len", 64'(last_len), 64'd1);

    // Length saturation on a packet longer than the length field.
    add_pkt(4100, 32'h1000_0000);
    drain("drain_saturate", 6000);
    check("saturate_len", 64'(last_len), 64'hFFF);
    check("saturate_pkt_cnt", 64'(pkt_cnt), STATS ? 64'd2 : 64'd0);

    // Random egress backpressure over several packets.
    add_pkt(3, 32'h2000_0000);
    add_pkt(1, 32'h3000_0000);
    add_pkt(4, 32'h4000_0000);
    for (int i = 0; i < 80; i++) begin
      eg_ready = 1'($urandom_range(0, 1));
      step();
    end
    eg_ready = 1'b1;
    drain("drain_random", 200);
    check("random_pkt_cnt", 64'(pkt_cnt), STATS ? 64'd5 : 64'd0);
    check("random_err_cnt", 64'(err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
